// File: rtl/mul_mac_sequencer.sv
// Multi-cycle MUL/MAC controller for the EX stage: sequences a radix-2 shift-add
// multiplier, owns the MAC accumulator and stalls the pipeline while busy.
module mul_mac_sequencer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             start,
    input  logic             mac_select,
    input  logic             flush,
    input  logic             acc_clear,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] acc_value
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MULT  = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state,   state_nxt;
    logic [CNT_W-1:0] cnt,     cnt_nxt;
    logic [WIDTH-1:0] mcand,   mcand_nxt;
    logic [WIDTH-1:0] mplier,  mplier_nxt;
    logic [WIDTH-1:0] product, product_nxt;
    logic [WIDTH-1:0] acc,     acc_nxt;
    logic [WIDTH-1:0] res,     res_nxt;
    logic             op_mac,  op_mac_nxt;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;

    // State and datapath registers
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            product <= '0;
            acc     <= '0;
            res     <= '0;
            op_mac  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            mcand   <= mcand_nxt;
            mplier  <= mplier_nxt;
            product <= product_nxt;
            acc     <= acc_nxt;
            res     <= res_nxt;
            op_mac  <= op_mac_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        mcand_nxt   = mcand;
        mplier_nxt  = mplier;
        product_nxt = product;
        acc_nxt     = acc;
        res_nxt     = res;
        op_mac_nxt  = op_mac;
        partial     = mplier[0] ? product + mcand : product;
        acc_sum     = acc + product;

        case (state)
            IDLE: begin
                if (acc_clear) begin
                    acc_nxt = '0;
                end
                if (start && !flush) begin
                    mcand_nxt   = operand_a;
                    mplier_nxt  = operand_b;
                    product_nxt = '0;
                    op_mac_nxt  = mac_select;
                    cnt_nxt     = '0;
                    state_nxt   = MULT;
                end
            end
            MULT: begin
                product_nxt = partial;
                mcand_nxt   = mcand << 1;
                mplier_nxt  = mplier >> 1;
                cnt_nxt     = cnt + CNT_W'(1);
                if (cnt == LAST_ITER) begin
                    if (op_mac) begin
                        state_nxt = ACCUM;
                    end else begin
                        res_nxt   = partial;
                        state_nxt = DONE;
                    end
                end
            end
            ACCUM: begin
                acc_nxt   = acc_sum;
                res_nxt   = acc_sum;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Abort wins over everything; a clear in IDLE still takes effect
        if (flush) begin
            state_nxt = IDLE;
            res_nxt   = res;
            if (state != IDLE) begin
                acc_nxt = acc;
            end
        end
    end

    assign stall     = (state == IDLE && start && !flush) || state == MULT || state == ACCUM;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign result    = res;
    assign acc_value = acc;

endmodule

// File: tb/tb_mul_mac_sequencer.sv
// Directed plus randomized bench for mul_mac_sequencer against a plain-arithmetic
// model of product, accumulator and latency.
module tb_mul_mac_sequencer;

    localparam int unsigned WIDTH = 32;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             start;
    logic             mac_select;
    logic             flush;
    logic             acc_clear;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] acc_value;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] m_acc = '0;

    mul_mac_sequencer #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .mac_select (mac_select),
        .flush      (flush),
        .acc_clear  (acc_clear),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .stall      (stall),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .acc_value  (acc_value)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op at the current cycle (called just after a rising edge) and
    // watch 40 cycles; flush_at >= 0 aborts it with a one-cycle flush then.
    task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic mac, input logic clr, input int flush_at);
        logic [31:0] exp_res;
        logic [31:0] got;
        int st, dn, dcyc;
        st = 0; dn = 0; dcyc = -1; got = 'x;
        if (clr) m_acc = '0;
        exp_res = a * b;
        if (mac) begin
            exp_res = m_acc + exp_res;
            if (flush_at < 0) m_acc = exp_res;
        end
        start = 1'b1; mac_select = mac; acc_clear = clr;
        operand_a = a; operand_b = b;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (stall) st++;
            if (done) begin dn++; dcyc = c; got = result; end
            if (flush_at >= 0 && c == flush_at + 1) chk({tag, "_busy_after_flush"}, 32'(busy), 32'd0);
            @(posedge clk); #1;
            start = 1'b0; acc_clear = 1'b0;
            flush = (c + 1 == flush_at);
        end
        if (flush_at < 0) begin
            chk({tag, "_stall_cycles"}, 32'(st), mac ? 32'd34 : 32'd33);
            chk({tag, "_done_count"}, 32'(dn), 32'd1);
            chk({tag, "_done_cycle"}, 32'(dcyc), mac ? 32'd34 : 32'd33);
            chk({tag, "_result"}, got, exp_res);
            chk({tag, "_result_held"}, result, exp_res);
        end else begin
            chk({tag, "_stall_cycles"}, 32'(st), 32'(flush_at + 1));
            chk({tag, "_done_count"}, 32'(dn), 32'd0);
        end
        chk({tag, "_acc"}, acc_value, m_acc);
    endtask

    initial begin
        int dn;
        int dcyc[2];
        logic [31:0] res_b2b[2];
        logic [31:0] ra, rb;
        logic rm, rc;

        arst_n = 1'b0; start = 1'b0; mac_select = 1'b0; flush = 1'b0;
        acc_clear = 1'b0; operand_a = '0; operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_acc", acc_value, 32'd0);
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;

        do_op("mul_7x6", 32'd7, 32'd6, 1'b0, 1'b0, -1);
        do_op("mul_wrap_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, -1);
        do_op("mul_wrap_msb", 32'h8000_0000, 32'd2, 1'b0, 1'b0, -1);
        do_op("mac_clr_3x4", 32'd3, 32'd4, 1'b1, 1'b1, -1);
        do_op("mac_5x5", 32'd5, 32'd5, 1'b1, 1'b0, -1);
        chk("acc_is_37", acc_value, 32'd37);
        do_op("mul_2x2", 32'd2, 32'd2, 1'b0, 1'b0, -1);
        do_op("flush_mult", 32'd100, 32'd100, 1'b1, 1'b0, 10);
        do_op("flush_accum", 32'd1, 32'd1, 1'b1, 1'b0, 33);
        chk("acc_still_37", acc_value, 32'd37);

        // start together with flush in IDLE is refused
        start = 1'b1; flush = 1'b1; operand_a = 32'd3; operand_b = 32'd3; mac_select = 1'b0;
        @(negedge clk);
        chk("idle_flush_stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("idle_flush_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // Back-to-back MUL(7,6) with start held through DONE
        dn = 0; dcyc[0] = -1; dcyc[1] = -1; res_b2b[0] = 'x; res_b2b[1] = 'x;
        start = 1'b1; mac_select = 1'b0; operand_a = 32'd7; operand_b = 32'd6;
        for (int c = 0; c < 75; c++) begin
            @(negedge clk);
            if (done) begin
                if (dn < 2) begin dcyc[dn] = c; res_b2b[dn] = result; end
                dn++;
            end
            if (c == 33) chk("b2b_stall_in_done", 32'(stall), 32'd0);
            if (c == 34) chk("b2b_stall_next", 32'(stall), 32'd1);
            @(posedge clk); #1;
            if (c == 34) start = 1'b0;
        end
        chk("b2b_done_count", 32'(dn), 32'd2);
        chk("b2b_done0_cycle", 32'(dcyc[0]), 32'd33);
        chk("b2b_done1_cycle", 32'(dcyc[1]), 32'd67);
        chk("b2b_result0", res_b2b[0], 32'd42);
        chk("b2b_result1", res_b2b[1], 32'd42);

        // Asynchronous reset in the middle of a MAC
        start = 1'b1; mac_select = 1'b1; operand_a = 32'd11; operand_b = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_acc", acc_value, 32'd0);
        m_acc = '0;
        @(negedge clk); arst_n = 1'b1;
        @(posedge clk); #1;
        do_op("mul_9x9", 32'd9, 32'd9, 1'b0, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = $urandom;
            rm = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 3) == 0);
            do_op($sformatf("rand%0d", i), ra, rb, rm, rc, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
